// File: rtl/wiener_pkg.sv
// Shared definitions for the Wiener filter front end.
//   WIDTH / COL_NUM : default data width and channel count, shared with the filter.
//   flush_state_e   : states of the bin flush sequencer in spike_bin_feeder.
package wiener_pkg;

  localparam int WIDTH   = 16;
  localparam int COL_NUM = 128;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_WRITE = 2'd1,
    F_START = 2'd2,
    F_WAIT  = 2'd3
  } flush_state_e;

endpackage

// File: rtl/spike_count_bank.sv
// One bank of per-channel spike counters.
//   clk, rst  : clock, synchronous active-high reset (clears every counter)
//   bulk_clr  : clear every counter this cycle (wins over inc/clr)
//   inc_v     : add one to counter inc_addr, holding at all-ones
//   inc_addr  : channel to increment
//   clr_v     : clear counter clr_addr (wins over a same-cycle increment)
//   clr_addr  : channel to clear
//   rd_addr   : combinational read address
//   rd_data   : current value of counter rd_addr
module spike_count_bank #(
  parameter int WIDTH   = 16,
  parameter int COL_NUM = 128,
  parameter int AW      = $clog2(COL_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bulk_clr,
  input  logic             inc_v,
  input  logic [AW-1:0]    inc_addr,
  input  logic             clr_v,
  input  logic [AW-1:0]    clr_addr,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] cnt_q [COL_NUM];
  logic [WIDTH-1:0] cnt_d [COL_NUM];

  always_comb begin
    for (int i = 0; i < COL_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bulk_clr) begin
        cnt_d[i] = '0;
      end else begin
        if (inc_v && (inc_addr == AW'(i)) && (cnt_q[i] != '1)) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
        if (clr_v && (clr_addr == AW'(i))) begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COL_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_data = cnt_q[rd_addr];

endmodule

// File: rtl/spike_bin_feeder.sv
// Spike binning front end for the Wiener filter.
// Counts spikes per channel over a BIN_CYCLES window into the active bank of a
// ping-pong pair, then streams the finished bin into the filter feature RAM and
// pulses start. Counting continues into the other bank while a bin is flushed.
//   clk, rst        : clock, synchronous active-high reset
//   enable          : runs the bin timer and counting; low clears the active bin
//   spike_v/spike_ch: one spike event on channel spike_ch (>= COL_NUM ignored)
//   finish_cal      : filter done pulse, honoured only while waiting for it
//   wr_data_addr    : feature RAM write address
//   ram_wr_data_en  : feature RAM write enable
//   ram_data_wr_in  : bin count written at wr_data_addr
//   start           : one-cycle filter start pulse
//   busy            : flush sequencer not idle
//   overrun         : one-cycle pulse, a bin was dropped
//   bin_cnt         : number of bins handed to the filter (wraps)
// Interface note: there is no backpressure anywhere. spike_v is a bare valid
// sampled every cycle; the RAM write port and start are fire-and-forget, and
// the only flow control is finish_cal releasing the sequencer.
module spike_bin_feeder #(
  parameter int  WIDTH      = wiener_pkg::WIDTH,
  parameter int  COL_NUM    = wiener_pkg::COL_NUM,
  parameter int  BIN_CYCLES = 1000000,
  parameter int  CH_W       = 8,
  localparam int Serial_COL = $clog2(COL_NUM) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  spike_v,
  input  logic [CH_W-1:0]       spike_ch,
  input  logic                  finish_cal,
  output logic [Serial_COL-1:0] wr_data_addr,
  output logic                  ram_wr_data_en,
  output logic [WIDTH-1:0]      ram_data_wr_in,
  output logic                  start,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           bin_cnt
);

  localparam int              AW     = $clog2(COL_NUM);
  localparam int              TW     = $clog2(BIN_CYCLES);
  localparam logic [TW-1:0]   T_LAST = TW'(BIN_CYCLES - 1);
  localparam logic [AW-1:0]   I_LAST = AW'(COL_NUM - 1);
  localparam logic [CH_W:0]   CH_LIM = (CH_W + 1)'(COL_NUM);

  wiener_pkg::flush_state_e state_q, state_d;

  logic [TW-1:0]         timer_q, timer_d;
  logic                  act_bank_q, act_bank_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [Serial_COL-1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           bin_cnt_q, bin_cnt_d;

  logic             spike_ok, boundary, accept, drop, act_clr, flush_clr;
  logic [AW-1:0]    flush_rd_addr;
  logic [WIDTH-1:0] rd0, rd1, act_rd, flush_rd, fwd0;

  // ---------------------------------------------------------------- control
  assign spike_ok      = enable & spike_v & ({1'b0, spike_ch} < CH_LIM);
  assign boundary      = enable & (timer_q == T_LAST);
  assign accept        = boundary & (state_q == wiener_pkg::F_IDLE);
  assign drop          = boundary & ~accept;
  assign act_clr       = ~enable | drop;
  // The output register runs one entry ahead of the counter being cleared.
  assign flush_rd_addr = idx_q + 1'b1;

  assign act_rd   = act_bank_q ? rd1 : rd0;
  assign flush_rd = act_bank_q ? rd0 : rd1;
  // Entry 0 is latched in the boundary cycle itself, so fold in a spike on
  // channel 0 that lands in that same cycle.
  assign fwd0 = (spike_ok && (spike_ch == '0) && (act_rd != '1)) ? act_rd + 1'b1 : act_rd;

  always_comb begin
    timer_d = timer_q + 1'b1;
    if (!enable || boundary) begin
      timer_d = '0;
    end
  end

  assign act_bank_d = act_bank_q ^ accept;

  // ---------------------------------------------------------------- banks
  spike_count_bank #(.WIDTH(WIDTH), .COL_NUM(COL_NUM), .AW(AW)) u_bank0 (
    .clk      (clk),
    .rst      (rst),
    .bulk_clr (~act_bank_q & act_clr),
    .inc_v    (~act_bank_q & spike_ok),
    .inc_addr (spike_ch[AW-1:0]),
    .clr_v    (act_bank_q & flush_clr),
    .clr_addr (idx_q),
    .rd_addr  (act_bank_q ? flush_rd_addr : '0),
    .rd_data  (rd0)
  );

  spike_count_bank #(.WIDTH(WIDTH), .COL_NUM(COL_NUM), .AW(AW)) u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .bulk_clr (act_bank_q & act_clr),
    .inc_v    (act_bank_q & spike_ok),
    .inc_addr (spike_ch[AW-1:0]),
    .clr_v    (~act_bank_q & flush_clr),
    .clr_addr (idx_q),
    .rd_addr  (act_bank_q ? '0 : flush_rd_addr),
    .rd_data  (rd1)
  );

  // ---------------------------------------------------------------- flush FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= wiener_pkg::F_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      wiener_pkg::F_IDLE:  if (accept) state_d = wiener_pkg::F_WRITE;
      wiener_pkg::F_WRITE: if (idx_q == I_LAST) state_d = wiener_pkg::F_START;
      wiener_pkg::F_START: state_d = wiener_pkg::F_WAIT;
      wiener_pkg::F_WAIT:  if (finish_cal) state_d = wiener_pkg::F_IDLE;
      default:             state_d = wiener_pkg::F_IDLE;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    addr_d    = '0;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    start_d   = 1'b0;
    bin_cnt_d = bin_cnt_q;
    flush_clr = 1'b0;
    case (state_q)
      wiener_pkg::F_IDLE: begin
        if (accept) begin
          idx_d     = '0;
          wr_en_d   = 1'b1;
          wr_data_d = fwd0;
        end
      end
      wiener_pkg::F_WRITE: begin
        flush_clr = 1'b1;
        if (idx_q != I_LAST) begin
          idx_d     = flush_rd_addr;
          addr_d    = {1'b0, flush_rd_addr};
          wr_en_d   = 1'b1;
          wr_data_d = flush_rd;
        end else begin
          start_d   = 1'b1;
          bin_cnt_d = bin_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
    busy_d    = (state_d != wiener_pkg::F_IDLE);
    overrun_d = drop;
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      act_bank_q <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      bin_cnt_q  <= '0;
    end else begin
      timer_q    <= timer_d;
      act_bank_q <= act_bank_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      bin_cnt_q  <= bin_cnt_d;
    end
  end

  assign wr_data_addr   = addr_q;
  assign ram_wr_data_en = wr_en_q;
  assign ram_data_wr_in = wr_data_q;
  assign start          = start_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;
  assign bin_cnt        = bin_cnt_q;

endmodule
